dot_channel_seq_18: RTL and testbench



---
 rtl/dot_channel_seq_18.sv | 132 +++++++++++++
 tb/tb_dot_channel_seq_18.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_channel_seq_18.sv
// Initiator-side sequencer for an 18-series dot channel: sweeps weight sets 0..NUM_CS-1,
// handshakes load/valid with the channel per set and packs every dot product into one result word.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module dot_channel_seq_18 #(
  parameter int NUM_CS     = 12,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [288*`DATA_LEN-1:0]     d_in,
  output logic                         busy,
  output logic                         dc_load,
  output logic [3:0]                   dc_cs,
  output logic [288*`DATA_LEN-1:0]     dc_d,
  input  logic                         dc_valid,
  input  logic [`DATA_LEN-1:0]         dc_q,
  output logic [NUM_CS*`DATA_LEN-1:0]  result,
  output logic                         done,
  output logic                         err,
  output logic [2:0]                   dbg_state
);

  // Handshake with the channel: dc_load is held high until the first cycle dc_valid is seen
  // high; that cycle's dc_q is the set's result, and dc_load then returns low for GAP_CYCLES
  // cycles so the channel's registered load history observes a low level before the next set.

  localparam int DL = `DATA_LEN;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic timeout_hit;
  logic gap_last;
  logic last_set;

  assign timeout_hit = (state == WAIT) && !dc_valid && (tcnt == TW'(TIMEOUT - 1));
  // The LOAD cycle is itself the final low cycle of the gap, so GAP lasts GAP_CYCLES-1 cycles
  // and dc_load stays low for exactly GAP_CYCLES cycles between sets.
  assign gap_last    = (state == GAP) && (gcnt == GW'(GAP_CYCLES - 2));
  assign last_set    = (dc_cs == 4'(NUM_CS - 1));

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: state_nx = WAIT;
      WAIT: begin
        if (dc_valid)         state_nx = GAP;
        else if (timeout_hit) state_nx = IDLE;
      end
      GAP:  if (gap_last) state_nx = last_set ? DONE : LOAD;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dc_load <= 1'b0;
      dc_cs   <= '0;
      dc_d    <= '0;
      result  <= '0;
      err     <= 1'b0;
      tcnt    <= '0;
      gcnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dc_d   <= d_in;
            dc_cs  <= '0;
            result <= '0;
            err    <= 1'b0;
          end
        end
        LOAD: begin
          dc_load <= 1'b1;
          tcnt    <= '0;
        end
        WAIT: begin
          if (dc_valid) begin
            for (int i = 0; i < NUM_CS; i++) begin
              if (dc_cs == 4'(i)) result[i*DL +: DL] <= dc_q;
            end
            dc_load <= 1'b0;
            gcnt    <= '0;
          end else if (timeout_hit) begin
            err     <= 1'b1;
            dc_load <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_last) begin
            if (!last_set) dc_cs <= dc_cs + 4'd1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_channel_seq_18.sv
// Self-checking bench for dot_channel_seq_18: a behavioural dot-channel responder, a load/cs
// monitor and one task per scenario, each comparing DUT outputs against the bench's own model.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module tb_dot_channel_seq_18;

  localparam int DL  = `DATA_LEN;
  localparam int DW  = 288 * DL;
  localparam int N   = 12;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DW-1:0]     d_in = '0;
  logic              busy;
  logic              dc_load;
  logic [3:0]        dc_cs;
  logic [DW-1:0]     dc_d;
  logic              dc_valid = 1'b0;
  logic [DL-1:0]     dc_q = '0;
  logic [N*DL-1:0]   result;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dot_channel_seq_18 #(.NUM_CS(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .d_in(d_in), .busy(busy),
    .dc_load(dc_load), .dc_cs(dc_cs), .dc_d(dc_d), .dc_valid(dc_valid), .dc_q(dc_q),
    .result(result), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Responder: valid after delay_cyc cycles of load high; the first q it presents per set is
  // what the sequencer must store, so it goes on the expected queue.
  int            mode = 0;        // 0: q = cs*3+1, 1: random q changing every cycle
  int            delay_cyc = 14;
  bit            rand_delay = 0;
  bit            noise = 0;
  int            fail_cs = -1;
  int            hcnt = 0;
  bit            presented = 0;
  logic [DL-1:0] exp_q[$];

  always @(negedge clk) begin
    if (dc_load) hcnt++;
    else begin
      hcnt = 0;
      presented = 0;
    end
    if (dc_load && hcnt == 1 && rand_delay) delay_cyc = $urandom_range(1, 20);
    if (dc_load && hcnt >= delay_cyc && int'(dc_cs) != fail_cs) begin
      dc_valid = 1'b1;
      if (mode == 1) dc_q = DL'($urandom);
      else           dc_q = DL'(int'(dc_cs) * 3 + 1);
      if (!presented) begin
        exp_q.push_back(dc_q);
        presented = 1;
      end
    end else begin
      dc_valid = noise && !dc_load && ($urandom_range(0, 1) == 1);
      dc_q = DL'($urandom);
    end
  end

  // Monitor: load pulses, cs order, low-gap lengths and stability of cs / dc_d.
  int            n_pulses, n_bad_gap, n_cs_move_hi, n_done, n_dd_change;
  int            low_run, hi_run, last_hi_run;
  int            cs_q[$];
  logic          prev_load = 1'b0;
  logic          prev_busy = 1'b0;
  logic [3:0]    prev_cs = '0;
  logic [DW-1:0] prev_dd = '0;

  always @(negedge clk) begin
    if (dc_load && !prev_load) begin
      cs_q.push_back(int'(dc_cs));
      if (n_pulses > 0 && low_run != GAP) n_bad_gap++;
      n_pulses++;
      hi_run = 0;
    end
    if (dc_load) hi_run++;
    if (!dc_load && prev_load) last_hi_run = hi_run;
    low_run = dc_load ? 0 : low_run + 1;
    if (dc_load && prev_load && dc_cs != prev_cs) n_cs_move_hi++;
    if (done) n_done++;
    if (busy && prev_busy && dc_d != prev_dd) n_dd_change++;
    prev_load = dc_load;
    prev_busy = busy;
    prev_cs   = dc_cs;
    prev_dd   = dc_d;
  end

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) v = (v << 32) | DW'($urandom);
    return v;
  endfunction

  task automatic clear_mon();
    n_pulses = 0; n_bad_gap = 0; n_cs_move_hi = 0; n_done = 0; n_dd_change = 0;
    low_run = 0; hi_run = 0; last_hi_run = 0;
    cs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic [DW-1:0] d);
    @(negedge clk);
    start = 1'b1;
    d_in  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done (status 1) or a timeout abort (status 2); optionally injects a start
  // carrying inj_d while set inj_cs is loading.
  task automatic run_sweep(input int inj_cs, input logic [DW-1:0] inj_d, output int status);
    bit injected;
    injected = 0;
    status = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (!injected && inj_cs >= 0 && dc_load && int'(dc_cs) == inj_cs) begin
        start = 1'b1;
        d_in = inj_d;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      if (done) begin status = 1; break; end
      if (err && !busy) begin status = 2; break; end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_tests++; if (dc_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %0b want 0", dc_load); end
    n_tests++; if (dc_cs !== 4'd0)   begin n_fail++; $display("FAIL reset_cs got %0d want 0", dc_cs); end
    n_tests++; if (dc_d !== '0)      begin n_fail++; $display("FAIL reset_dc_d not zero"); end
    n_tests++; if (result !== '0)    begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
    n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %0b want 0", err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [DW-1:0] a;
    int st;
    a = rand_vec();
    mode = 0; delay_cyc = 14; rand_delay = 0; noise = 0; fail_cs = -1;
    clear_mon();
    pulse_start(a);
    n_tests++; if (busy !== 1'b1 || dc_load !== 1'b0) begin
      n_fail++; $display("FAIL nom_accept busy=%0b load=%0b want busy=1 load=0", busy, dc_load);
    end
    @(negedge clk);
    n_tests++; if (dc_load !== 1'b1 || dc_cs !== 4'd0) begin
      n_fail++; $display("FAIL nom_load_rise load=%0b cs=%0d want load=1 cs=0", dc_load, dc_cs);
    end
    run_sweep(-1, '0, st);
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL nom_status got %0d want 1", st); end
    n_tests++; if (n_pulses != N) begin n_fail++; $display("FAIL nom_pulses got %0d want %0d", n_pulses, N); end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (i >= cs_q.size() || cs_q[i] != i) begin
        n_fail++; $display("FAIL nom_cs_order idx %0d got %0d want %0d", i, (i < cs_q.size()) ? cs_q[i] : -1, i);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (result[i*DL +: DL] !== DL'(3 * i + 1)) begin
        n_fail++; $display("FAIL nom_slot%0d got %0d want %0d", i, result[i*DL +: DL], 3 * i + 1);
      end
    end
    n_tests++; if (dc_d !== a) begin n_fail++; $display("FAIL nom_dc_d differs from pattern A"); end
    n_tests++; if (n_dd_change != 0) begin n_fail++; $display("FAIL nom_dc_d_stable got %0d changes want 0", n_dd_change); end
    n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL nom_done_count got %0d want 1", n_done); end
    n_tests++; if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nom_end err=%0b busy=%0b want 0 0", err, busy);
    end
  endtask

  task automatic test_load_gap();
    int st;
    mode = 0; rand_delay = 1; noise = 1; fail_cs = -1;
    clear_mon();
    pulse_start(rand_vec());
    run_sweep(-1, '0, st);
    noise = 0; rand_delay = 0;
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL gap_status got %0d want 1", st); end
    n_tests++; if (n_bad_gap != 0) begin n_fail++; $display("FAIL gap_low_len bad gaps got %0d want 0", n_bad_gap); end
    n_tests++; if (n_cs_move_hi != 0) begin n_fail++; $display("FAIL gap_cs_stable got %0d moves want 0", n_cs_move_hi); end
    n_tests++; if (exp_q.size() != N) begin n_fail++; $display("FAIL gap_exp_count got %0d want %0d", exp_q.size(), N); end
    for (int i = 0; i < N && exp_q.size() > 0; i++) begin
      logic [DL-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (result[i*DL +: DL] !== e) begin n_fail++; $display("FAIL gap_slot%0d got %0d want %0d", i, result[i*DL +: DL], e); end
    end
  endtask

  task automatic test_held_valid();
    int st;
    mode = 1; delay_cyc = 3; rand_delay = 0; noise = 0; fail_cs = -1;
    clear_mon();
    pulse_start(rand_vec());
    run_sweep(-1, '0, st);
    mode = 0;
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL held_status got %0d want 1", st); end
    n_tests++; if (exp_q.size() != N) begin n_fail++; $display("FAIL held_exp_count got %0d want %0d", exp_q.size(), N); end
    for (int i = 0; i < N && exp_q.size() > 0; i++) begin
      logic [DL-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (result[i*DL +: DL] !== e) begin n_fail++; $display("FAIL held_slot%0d got %0d want %0d", i, result[i*DL +: DL], e); end
    end
  endtask

  task automatic test_timeout();
    int st;
    mode = 0; delay_cyc = 14; rand_delay = 0; noise = 0; fail_cs = 5;
    clear_mon();
    pulse_start(rand_vec());
    run_sweep(-1, '0, st);
    n_tests++; if (st != 2) begin n_fail++; $display("FAIL to_status got %0d want 2", st); end
    n_tests++; if (last_hi_run != TO) begin n_fail++; $display("FAIL to_wait_len got %0d want %0d", last_hi_run, TO); end
    n_tests++; if (err !== 1'b1 || dc_load !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_flags err=%0b load=%0b busy=%0b want 1 0 0", err, dc_load, busy);
    end
    n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL to_no_done got %0d want 0", n_done); end
    for (int i = 0; i < N; i++) begin
      logic [DL-1:0] e;
      e = (i < 5) ? DL'(3 * i + 1) : '0;
      n_tests++;
      if (result[i*DL +: DL] !== e) begin n_fail++; $display("FAIL to_slot%0d got %0d want %0d", i, result[i*DL +: DL], e); end
    end
    fail_cs = -1;
    clear_mon();
    pulse_start(rand_vec());
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %0b want 0", err); end
    run_sweep(-1, '0, st);
    n_tests++; if (st != 1 || err !== 1'b0) begin n_fail++; $display("FAIL to_recover status=%0d err=%0b want 1 0", st, err); end
    n_tests++; if (result[11*DL +: DL] !== DL'(34)) begin n_fail++; $display("FAIL to_recover_slot11 got %0d want 34", result[11*DL +: DL]); end
  endtask

  task automatic test_start_busy();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int st;
    a = rand_vec();
    b = ~a;
    mode = 0; delay_cyc = 6; rand_delay = 0; noise = 0; fail_cs = -1;
    clear_mon();
    pulse_start(a);
    run_sweep(3, b, st);
    n_tests++; if (st != 1) begin n_fail++; $display("FAIL busy_status got %0d want 1", st); end
    n_tests++; if (dc_d !== a) begin n_fail++; $display("FAIL busy_dc_d changed by ignored start"); end
    n_tests++; if (n_dd_change != 0 || n_pulses != N || n_done != 1) begin
      n_fail++; $display("FAIL busy_sweep dd_changes=%0d pulses=%0d dones=%0d want 0 %0d 1", n_dd_change, n_pulses, n_done, N);
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (result[i*DL +: DL] !== DL'(3 * i + 1)) begin
        n_fail++; $display("FAIL busy_slot%0d got %0d want %0d", i, result[i*DL +: DL], 3 * i + 1);
      end
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after got %0b want 0", busy); end
  endtask

  task automatic test_async_reset();
    int st;
    bit hit;
    mode = 0; delay_cyc = 10; rand_delay = 0; noise = 0; fail_cs = -1;
    clear_mon();
    pulse_start(rand_vec());
    hit = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (dc_load && dc_cs == 4'd4 && hcnt > 3) begin hit = 1; break; end
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_reach_wait got 0 want 1"); end
    #3 rst = 1'b1;
    #1;
    n_tests++; if (dc_load !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_flags load=%0b busy=%0b done=%0b err=%0b want 0", dc_load, busy, done, err);
    end
    n_tests++; if (dc_cs !== 4'd0 || result !== '0) begin
      n_fail++; $display("FAIL rst_async_regs cs=%0d result=%h want 0", dc_cs, result);
    end
    @(negedge clk);
    rst = 1'b0;
    mode = 1; rand_delay = 1; noise = 1;
    clear_mon();
    pulse_start(rand_vec());
    run_sweep(-1, '0, st);
    mode = 0; rand_delay = 0; noise = 0;
    n_tests++; if (st != 1 || n_pulses != N) begin n_fail++; $display("FAIL rst_resweep status=%0d pulses=%0d want 1 %0d", st, n_pulses, N); end
    n_tests++; if (exp_q.size() != N) begin n_fail++; $display("FAIL rst_exp_count got %0d want %0d", exp_q.size(), N); end
    for (int i = 0; i < N && exp_q.size() > 0; i++) begin
      logic [DL-1:0] e;
      e = exp_q.pop_front();
      n_tests++;
      if (result[i*DL +: DL] !== e) begin n_fail++; $display("FAIL rst_slot%0d got %0d want %0d", i, result[i*DL +: DL], e); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_load_gap();
    test_held_valid();
    test_timeout();
    test_start_busy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
